// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of an asynchronous PWM line.
// It counts clk cycles between pwm_in edges after a 2-flop synchronizer.
// high_cnt and period_cnt update together, and meas_valid pulses for one cycle
// after each complete period.
// A run counter that saturates with no edge means loss of signal: the FSM
// drops back to IDLE.
// Optional feature macro: PWM_CAPTURE_STUCK_DETECT_EN. When it is defined, a
// saturated run counter also raises stuck and records the line level in
// stuck_level. When it is undefined, stuck and stuck_level are tied low.
//
// Output protocol: meas_valid is a one-cycle strobe with no ready/backpressure.
// high_cnt and period_cnt are valid on the cycle meas_valid is high. They hold
// their values until the next strobe or reset.
module pwm_capture #(
  parameter int CTR_LEN = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pwm_in,
  output logic [CTR_LEN-1:0] high_cnt,
  output logic [CTR_LEN-1:0] period_cnt,
  output logic               meas_valid,
  output logic               stuck,
  output logic               stuck_level
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [CTR_LEN-1:0] CNT_MAX = '1;

  logic               sync1;
  logic               s;
  logic               s_prev;
  logic               rise;
  logic               fall;
  logic               sat;
  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [CTR_LEN-1:0] run_cnt;
  logic [CTR_LEN-1:0] hi_lat;

  // Synchronize pwm_in and keep the previous synchronized level for edge detect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      s      <= sync1;
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;
  // Saturation only counts when no edge arrives that cycle; an edge always wins.
  assign sat  = (run_cnt == CNT_MAX) && !rise && !fall;

  // Run counter: restarts at 1 on each rise and otherwise counts up, saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt <= '0;
    end else if (rise) begin
      run_cnt <= CTR_LEN'(1);
    end else if (run_cnt != CNT_MAX) begin
      run_cnt <= run_cnt + CTR_LEN'(1);
    end
  end

  // Next-state logic: follow the edges, or fall back to IDLE on saturation.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        if (fall)     state_nxt = LOW;
        else if (sat) state_nxt = IDLE;
      end
      LOW: begin
        if (rise)     state_nxt = HIGH;
        else if (sat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch the high time on the falling edge, then publish both counts on the
  // next rise. A rise that leaves IDLE only starts a measurement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_lat     <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (state == HIGH && fall) begin
        hi_lat <= run_cnt;
      end
      if (state == LOW && rise) begin
        period_cnt <= run_cnt;
        high_cnt   <= hi_lat;
        meas_valid <= 1'b1;
      end
    end
  end

`ifdef PWM_CAPTURE_STUCK_DETECT_EN
  // Stuck flag: set on saturation with the current level, cleared by any edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else if (rise || fall) begin
      stuck <= 1'b0;
    end else if (sat && !stuck) begin
      stuck       <= 1'b1;
      stuck_level <= s;
    end
  end
`else
  assign stuck       = 1'b0;
  assign stuck_level = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed test of pwm_capture with two instances sharing the
// same stimulus. One instance uses CTR_LEN=16 and the other CTR_LEN=8, so the
// narrow one can saturate within a short run.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pwm_in = 1'b0;

  logic [15:0] hi16, per16;
  logic        mv16, st16, sl16;
  logic [7:0]  hi8, per8;
  logic        mv8, st8, sl8;

`ifdef PWM_CAPTURE_STUCK_DETECT_EN
  localparam logic EXP_STUCK = 1'b1;
`else
  localparam logic EXP_STUCK = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;

  int checks = 0;
  int errors = 0;

  // Pulse bookkeeping for the current stimulus window.
  int          tick_i;
  int          p16_n, p16_at, p8_n;
  logic [15:0] p16_hi, p16_per;
  logic [7:0]  p8_hi, p8_per;

  pwm_capture #(.CTR_LEN(16)) dut16 (
    .clk(clk), .rstn(rstn), .pwm_in(pwm_in),
    .high_cnt(hi16), .period_cnt(per16), .meas_valid(mv16),
    .stuck(st16), .stuck_level(sl16)
  );

  pwm_capture #(.CTR_LEN(8)) dut8 (
    .clk(clk), .rstn(rstn), .pwm_in(pwm_in),
    .high_cnt(hi8), .period_cnt(per8), .meas_valid(mv8),
    .stuck(st8), .stuck_level(sl8)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles and sample 1 time unit after each rising edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tick_i++;
      if (mv16 === 1'b1) begin
        p16_n++;
        p16_at  = tick_i;
        p16_hi  = hi16;
        p16_per = per16;
      end
      if (mv8 === 1'b1) begin
        p8_n++;
        p8_hi  = hi8;
        p8_per = per8;
      end
    end
  endtask

  task automatic clr();
    tick_i = 0;
    p16_n  = 0;
    p16_at = 0;
    p8_n   = 0;
  endtask

  // Drive one PWM period: h cycles high, then p-h cycles low.
  task automatic drive_period(input int h, input int p);
    clr();
    pwm_in = 1'b1;
    tick_n(h);
    pwm_in = 1'b0;
    tick_n(p - h);
  endtask

  initial begin
    clr();
    // Reset state.
    rstn = 1'b0;
    pwm_in = 1'b0;
    tick_n(3);
    chk("rst_high_cnt", hi16, 0);
    chk("rst_period_cnt", per16, 0);
    chk("rst_meas_valid", mv16, 0);
    chk("rst_stuck", st16, 0);
    chk("rst_stuck_level", sl16, 0);
    chk("rst_state", dut16.state, ST_IDLE);
    rstn = 1'b1;
    tick_n(4);

    // Steady 3/8 stream: the first rise only starts a measurement.
    drive_period(3, 8);
    chk("p1_pulses16", p16_n, 0);
    chk("p1_pulses8", p8_n, 0);
    drive_period(3, 8);
    chk("p2_pulses16", p16_n, 1);
    // The sampling edge, the synchronizer edge, then the update edge.
    chk("p2_latency", p16_at, 3);
    chk("p2_high16", p16_hi, 3);
    chk("p2_period16", p16_per, 8);
    chk("p2_pulses8", p8_n, 1);
    chk("p2_high8", p8_hi, 3);
    chk("p2_period8", p8_per, 8);
    drive_period(3, 8);
    chk("p3_pulses16", p16_n, 1);
    chk("p3_high16", p16_hi, 3);
    chk("p3_period16", p16_per, 8);

    // Duty change to 6/8: old values are held until the next strobe.
    clr();
    pwm_in = 1'b1;
    tick_n(1);
    chk("d1_hold_high", hi16, 3);
    chk("d1_hold_period", per16, 8);
    tick_n(5);
    pwm_in = 1'b0;
    tick_n(2);
    chk("d1_pulses", p16_n, 1);
    chk("d1_high", p16_hi, 3);
    chk("d1_period", p16_per, 8);
    clr();
    pwm_in = 1'b1;
    tick_n(2);
    chk("d2_hold_high", hi16, 3);
    tick_n(4);
    pwm_in = 1'b0;
    tick_n(2);
    chk("d2_pulses", p16_n, 1);
    chk("d2_high", p16_hi, 6);
    chk("d2_period", p16_per, 8);

    // Hold the line high for 300 cycles. The 8-bit run counter hits 255
    // 257 cycles after the rise is sampled.
    clr();
    pwm_in = 1'b1;
    tick_n(257);
    chk("s_close_pulses8", p8_n, 1);
    chk("s_close_high8", p8_hi, 6);
    chk("s_close_period8", p8_per, 8);
    chk("s_pre_stuck8", st8, 0);
    tick_n(1);
    chk("s_stuck8", st8, EXP_STUCK);
    chk("s_stuck_level8", sl8, EXP_STUCK);
    chk("s_state8", dut8.state, ST_IDLE);
    chk("s_stuck16", st16, 0);
    tick_n(42);
    chk("s_no_extra8", p8_n, 1);
    chk("s_hold_high8", hi8, 6);
    chk("s_hold_period8", per8, 8);
    chk("s_still_stuck8", st8, EXP_STUCK);
    chk("s_idle8", dut8.state, ST_IDLE);
    clr();
    pwm_in = 1'b0;
    tick_n(2);
    chk("s_fall_pending8", st8, EXP_STUCK);
    tick_n(1);
    chk("s_fall_clear8", st8, 0);
    tick_n(10);
    chk("s_fall_pulses8", p8_n, 0);
    chk("s_fall_high8", hi8, 6);
    chk("s_fall_period8", per8, 8);
    chk("s_fall_idle8", dut8.state, ST_IDLE);

    // Reset in the middle of a HIGH phase.
    clr();
    pwm_in = 1'b1;
    tick_n(5);
    chk("r_in_high16", dut16.state, ST_HIGH);
    rstn = 1'b0;
    #1;
    chk("r_high16", hi16, 0);
    chk("r_period16", per16, 0);
    chk("r_valid16", mv16, 0);
    chk("r_stuck16", st16, 0);
    chk("r_level16", sl16, 0);
    chk("r_high8", hi8, 0);
    chk("r_stuck8", st8, 0);
    pwm_in = 1'b0;
    tick_n(2);
    rstn = 1'b1;
    tick_n(5);
    drive_period(3, 8);
    chk("r_first_pulses", p16_n, 0);
    drive_period(5, 8);
    chk("r_second_pulses", p16_n, 1);
    chk("r_second_high", p16_hi, 3);
    chk("r_second_period", p16_per, 8);

    // pwm_in already high when reset is released.
    pwm_in = 1'b1;
    rstn = 1'b0;
    tick_n(2);
    chk("h_rst_high16", hi16, 0);
    rstn = 1'b1;
    drive_period(4, 10);
    chk("h_first_pulses16", p16_n, 0);
    chk("h_first_pulses8", p8_n, 0);
    drive_period(4, 10);
    chk("h_pulses16", p16_n, 1);
    chk("h_high16", p16_hi, 4);
    chk("h_period16", p16_per, 10);
    chk("h_pulses8", p8_n, 1);
    chk("h_high8", p8_hi, 4);
    chk("h_period8", p8_per, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
